// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the 8-bit CPU decoder. This block owns the program counter
// (PC) and the instruction register (IR).
//   - Fetch: reads the byte at PC from program memory using a ready
//     handshake and latches it into IR.
//   - Hold: while that read is outstanding, it asks the sequence generator
//     to stop its clock enable.
//   - Increment: advances PC to PC+1, or to a jump target that the decoder
//     resolved during the execute phase.
//
// Ports
//   clock          system clock; all state changes on the rising edge
//   input_clear    synchronous active-high reset
//   fetch          fetch phase strobe
//   execute        execute phase strobe
//   increment      increment phase strobe (PC advances on its rising edge)
//   output_jump*   jump strobes from the decoder
//   flag_zero      ALU zero flag
//   flag_carry     ALU carry flag
//   input_target   jump destination address
//   mem_addr       registered program memory address
//   mem_read       registered read request
//   mem_ready      memory data valid this cycle
//   mem_data       instruction byte from memory
//   output_ir      instruction register, feeds the decoder
//   output_pc      current PC
//   output_hold    combinational request to drop the sequencer clock enable
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       input_clear,
    input  logic       fetch,
    input  logic       execute,
    input  logic       increment,
    input  logic       output_jump,
    input  logic       output_jumpz,
    input  logic       output_jumpnz,
    input  logic       output_jumpc,
    input  logic       output_jumpnc,
    input  logic       flag_zero,
    input  logic       flag_carry,
    input  logic [7:0] input_target,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    input  logic       mem_ready,
    input  logic [7:0] mem_data,
    output logic [7:0] output_ir,
    output logic [7:0] output_pc,
    output logic       output_hold
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] target_r;
    logic       taken_r;
    logic       taken;
    logic       incr_p1;
    logic       incr_rise;

    // 8-bit PC arithmetic wraps naturally from 8'hFF to 8'h00.
    function automatic logic [7:0] next_pc(input logic       take,
                                           input logic [7:0] tgt,
                                           input logic [7:0] cur);
        next_pc = take ? tgt : cur + 8'd1;
    endfunction

    assign taken = output_jump
                 | (output_jumpz  &  flag_zero)
                 | (output_jumpnz & ~flag_zero)
                 | (output_jumpc  &  flag_carry)
                 | (output_jumpnc & ~flag_carry);

    assign incr_rise = increment & ~incr_p1;

    assign output_ir = ir;
    assign output_pc = pc;

    // ---- fetch FSM: state register ----
    always_ff @(posedge clock) begin
        if (input_clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- fetch FSM: next state and hold request ----
    always_comb begin
        state_next  = state;
        output_hold = 1'b0;
        case (state)
            IDLE: begin
                // mem_ready is ignored here, so a late reply from a read
                // abandoned by reset cannot load IR.
                if (fetch) begin
                    output_hold = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                output_hold = 1'b1;
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Wait for the fetch strobe to drop so that one phase
                // produces exactly one read.
                if (!fetch) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- memory port, IR, jump capture and PC update ----
    always_ff @(posedge clock) begin
        if (input_clear) begin
            pc       <= RESET_PC;
            ir       <= 8'h00;
            mem_read <= 1'b0;
            mem_addr <= 8'h00;
            taken_r  <= 1'b0;
            target_r <= 8'h00;
            incr_p1  <= 1'b0;
        end else begin
            if (state == IDLE && fetch) begin
                mem_read <= 1'b1;
                mem_addr <= pc;
            end
            if (state == REQ && mem_ready) begin
                ir       <= mem_data;
                mem_read <= 1'b0;
            end

            incr_p1 <= increment;

            // Consuming a pending jump takes priority. A jump resolved in
            // the same cycle as the increment edge is dropped, so execute
            // has to come before increment.
            if (incr_rise) begin
                pc      <= next_pc(taken_r, target_r, pc);
                taken_r <= 1'b0;
            end else if (execute && taken) begin
                taken_r  <= 1'b1;
                target_r <= input_target;
            end
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream stage of the complete instruction decoder: owns the program counter (PC) and instruction register (IR) of the 8-bit CPU. It fetches the instruction at PC from program memory through a ready handshake during the fetch phase, presents it to the decoder, and updates PC during the increment phase. PC+1 is used unless the decoder flagged a taken jump during execute. While a memory read is outstanding, it holds the sequence generator by requesting clock-enable removal.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- clock  in  1  system clock; all state changes on rising edge
- input_clear  in  1  synchronous, active-high reset
- fetch  in  1  fetch phase strobe from sequence generator
- execute  in  1  execute phase strobe
- increment  in  1  increment phase strobe
- output_jump, output_jumpz, output_jumpnz, output_jumpc, output_jumpnc  in  1 each  jump strobes from decoder
- flag_zero  in  1  ALU zero flag
- flag_carry  in  1  ALU carry flag
- input_target  in  8  jump destination address from datapath
- mem_addr  out  8  program memory address
- mem_read  out  1  read request, registered
- mem_ready  in  1  memory data valid this cycle
- mem_data  in  8  instruction byte
- output_ir  out  8  instruction register; drives decoder input_a
- output_pc  out  8  current PC
- output_hold  out  1  high = sequence generator must deassert input_clock_enable

## Operation
- Fetch FSM states: IDLE, REQ, DONE.
- IDLE:
  - If fetch=1: output_hold=1 (combinational), next state REQ, mem_read<=1, mem_addr<=PC.
  - mem_ready is ignored in IDLE.
- REQ:
  - output_hold=1; mem_read stays 1.
  - On mem_ready=1: IR<=mem_data, mem_read<=0, next state DONE.
- DONE:
  - output_hold=0.
  - Stays DONE while fetch=1; returns to IDLE when fetch=0, so one fetch phase yields exactly one read.
- Jump resolution, evaluated each cycle with execute=1:
  - taken = jump | (jumpz & flag_zero) | (jumpnz & ~flag_zero) | (jumpc & flag_carry) | (jumpnc & ~flag_carry)
  - If taken=1: taken_r<=1 and target_r<=input_target.
  - taken_r is sticky until consumed by the increment update.
- Increment update: occurs only on the cycle where increment=1 and increment was 0 in the previous cycle (registered edge detect).
  - PC <= taken_r ? target_r : PC+1, modulo 256 (8'hFF+1 -> 8'h00).
  - taken_r <= 0 in the same cycle.
- Holding increment high for several cycles changes PC once.
- IR changes only on REQ & mem_ready; it is stable through decode and execute.
- Reset (input_clear=1), at any state including mid-REQ:
  - PC=RESET_PC, IR=8'h00, state IDLE, mem_read=0, mem_addr=8'h00, taken_r=0, target_r=8'h00, edge register=0.
  - output_hold=0 unless fetch=1 in the first cycle after reset.
  - A late mem_ready from the abandoned read is ignored.

## Timing
- Minimum fetch latency: 3 cycles from the first fetch=1 cycle to output_hold=0, with mem_ready in the first REQ cycle. Each cycle mem_ready is delayed adds one cycle.
- output_ir is valid from the cycle after mem_ready is sampled.
- mem_addr and mem_read change only on clock edges.
- PC changes 1 cycle after increment rises; the new value is visible on output_pc and used by the next fetch.
- If execute=1 and increment rises in the same cycle, that cycle's taken is not applied; execute must precede increment.
- If fetch and increment are both high, both actions occur; PC updates after the mem_addr capture.

## Test plan
- Reset then straight-line run:
  - Stimulus: memory returns 8'h40 at addr 0 and 8'h60 at addr 1; mem_ready one cycle after mem_read.
  - Required: IR=8'h40 then 8'h60; PC goes 0 -> 1 -> 2; output_hold high for exactly 2 cycles per fetch.
- Unconditional jump:
  - Stimulus: output_jump=1 during execute with input_target=8'h2A.
  - Required: after the increment edge PC=8'h2A; the next mem_addr=8'h2A.
- Conditional jumps:
  - jumpz with flag_zero=0 -> PC+1.
  - jumpnz with flag_zero=0 -> target.
  - jumpc with flag_carry=1 -> target.
  - jumpnc with flag_carry=1 -> PC+1.
- Wait states:
  - Stimulus: mem_ready delayed 4 cycles.
  - Required: output_hold stays 1 for 5 cycles; IR unchanged until mem_ready.
- Wrap and long increment:
  - Stimulus: PC=8'hFF, increment held high for 3 cycles.
  - Required: PC=8'h00, incremented once only.
- Reset mid-REQ:
  - Stimulus: input_clear=1 while mem_read=1, then mem_ready=1 with mem_data=8'hE0.
  - Required: PC=RESET_PC, IR=8'h00, mem_read=0, state IDLE.
